// File: rtl/spi_arb_pkg.sv
// Shared state encoding and default constants for the SPI round-robin arbiter.
package spi_arb_pkg;
   typedef enum logic [2:0] {IDLE, ARB, ISSUE, BUSY, ACK} arb_state_t;

   localparam int SPI_DATA_W          = 12;
   localparam int SPI_ARB_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               vld_o
);
   logic [PW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      vld_o = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PW'((int'(ptr_i) + k) % NUM_REQ);
         if (!vld_o && req_i[idx]) begin
            vld_o      = 1'b1;
            gnt_o[idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Optional frame timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = SPI_DATA_W,
   parameter int TIMEOUT_CYC = SPI_ARB_TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      err,
   output logic                      busy,
   output logic                      spi_newd,
   output logic [DATA_W-1:0]         spi_din,
   input  logic                      spi_cs
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t          state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  win_q, win_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                cs_q;
   logic [NUM_REQ-1:0]  pick_oh;
   logic                pick_vld;
   logic [DATA_W-1:0]   pick_data;
   logic [PW-1:0]       win_idx;
   logic                tmo;

   rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick_oh),
      .vld_o (pick_vld)
   );

   always_comb begin
      pick_data = '0;
      win_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) pick_data = req_data[i*DATA_W +: DATA_W];
         if (win_q[i])   win_idx   = PW'(i);
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] tcnt_q, tcnt_d;

   always_comb begin
      tcnt_d = tcnt_q;
      if (state_q == ARB)                           tcnt_d = '0;
      else if (state_q == ISSUE || state_q == BUSY) tcnt_d = tcnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) tcnt_q <= '0;
      else      tcnt_q <= tcnt_d;
   end

   assign tmo = (state_q == ISSUE || state_q == BUSY) && (tcnt_q == CW'(TIMEOUT_CYC));
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      win_d   = win_q;
      din_d   = din_q;
      unique case (state_q)
         IDLE:  if (|req) state_d = ARB;
         ARB: begin
            if (pick_vld) begin
               gnt_d   = pick_oh;
               win_d   = pick_oh;
               din_d   = pick_data;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (tmo) begin
               gnt_d   = '0;
               ptr_d   = win_idx;
               state_d = IDLE;
            end else if (!cs_q) begin
               state_d = BUSY;
            end
         end
         // A frame end seen in the timeout cycle still completes normally.
         BUSY: begin
            if (cs_q) begin
               gnt_d   = '0;
               state_d = ACK;
            end else if (tmo) begin
               gnt_d   = '0;
               ptr_d   = win_idx;
               state_d = IDLE;
            end
         end
         ACK: begin
            ptr_d   = win_idx;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NUM_REQ - 1);
         gnt_q   <= '0;
         win_q   <= '0;
         din_q   <= '0;
         cs_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         win_q   <= win_d;
         din_q   <= din_d;
         cs_q    <= spi_cs;
      end
   end

   assign gnt      = gnt_q;
   assign ack      = (state_q == ACK) ? win_q : '0;
   assign err      = tmo;
   assign busy     = (state_q != IDLE);
   assign spi_newd = (state_q == ISSUE) && !tmo;
   assign spi_din  = din_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter with a behavioural SPI master and round-robin model.
`timescale 1ns/1ps
module tb_spi_arbiter;
   localparam int NR  = 4;
   localparam int DW  = 12;
   localparam int TMO = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     gnt, ack;
   logic              err, busy, spi_newd;
   logic [DW-1:0]     spi_din;
   logic              spi_cs = 1'b1;

   int            n_chk = 0;
   int            n_fail = 0;
   int            model_ptr = NR - 1;
   logic [DW-1:0] sent_q[$];
   bit            cs_tie = 1'b0;
   logic [NR-1:0] prev_gnt = '0;

   always #5 clk = ~clk;

   spi_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .gnt(gnt), .ack(ack), .err(err), .busy(busy),
      .spi_newd(spi_newd), .spi_din(spi_din), .spi_cs(spi_cs)
   );

   // Behavioural master: accepts newd after a random delay, captures din, runs a frame.
   initial begin
      forever begin
         @(negedge clk);
         if (!cs_tie && rst && spi_newd && spi_cs) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            spi_cs = 1'b0;
            sent_q.push_back(spi_din);
            repeat (DW + $urandom_range(0, 8)) @(negedge clk);
            spi_cs = 1'b1;
            repeat (2) @(negedge clk);
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         n_chk++;
         if ($countones(gnt) > 1) begin
            n_fail++;
            $display("FAIL gnt_onehot: gnt=%b, required at most one bit set", gnt);
         end
         if (ack != '0) begin
            n_chk++;
            if (ack !== prev_gnt) begin
               n_fail++;
               $display("FAIL ack_vs_prev_gnt: ack=%b, required previous gnt=%b", ack, prev_gnt);
            end
         end
      end
      prev_gnt = gnt;
   end

   function automatic int model_pick(input logic [NR-1:0] r, input int p);
      for (int k = 1; k <= NR; k++)
         if (r[(p + k) % NR]) return (p + k) % NR;
      return -1;
   endfunction

   function automatic logic [NR-1:0] onehot(input int i);
      return NR'(1) << i;
   endfunction

   function automatic logic [DW-1:0] word(input int i);
      return req_data[i*DW +: DW];
   endfunction

   task automatic set_word(input int i, input logic [DW-1:0] w);
      req_data[i*DW +: DW] = w;
   endtask

   task automatic wait_ack(output logic [NR-1:0] a, output bit to);
      a  = '0;
      to = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (ack != '0) begin
            a  = ack;
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      for (int i = 0; i < 200 && spi_cs !== 1'b1; i++) @(negedge clk);
      req = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_ptr = NR - 1;
      sent_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req = '0;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({gnt, ack, err, busy, spi_newd} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b ack=%b err=%b busy=%b newd=%b, required all 0",
                  gnt, ack, err, busy, spi_newd);
      end
      n_chk++;
      if (spi_din !== '0) begin
         n_fail++;
         $display("FAIL reset_din: spi_din=%h, required 000", spi_din);
      end
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_req: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_single();
      logic [NR-1:0] a;
      bit to, seen;
      int drops, e;
      logic [DW-1:0] got;
      set_word(0, 12'hA5C);
      req = 4'b0001;
      e = model_pick(req, model_ptr);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (spi_newd) begin seen = 1'b1; break; end
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL single_newd: newd never rose, required 1 within 50 cycles");
      end
      drops = 0;
      for (int i = 0; i < 100 && spi_cs; i++) begin
         if (!spi_newd) drops++;
         @(negedge clk);
      end
      n_chk++;
      if (drops != 0 || spi_cs !== 1'b0) begin
         n_fail++;
         $display("FAIL single_newd_hold: newd low %0d cycles before cs fell (cs=%b), required 0", drops, spi_cs);
      end
      wait_ack(a, to);
      n_chk++;
      if (to || a !== onehot(e)) begin
         n_fail++;
         $display("FAIL single_ack: ack=%b timeout=%0d, required %b", a, to, onehot(e));
      end
      model_ptr = e;
      req = '0;
      @(negedge clk);
      n_chk++;
      if (ack !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_after_ack: ack=%b busy=%b, required ack=0 busy=0", ack, busy);
      end
      got = (sent_q.size() > 0) ? sent_q.pop_front() : 'x;
      n_chk++;
      if (got !== 12'hA5C) begin
         n_fail++;
         $display("FAIL single_word: slave got %h, required a5c", got);
      end
   endtask

   task automatic test_simultaneous();
      logic [NR-1:0] a;
      bit to;
      int e;
      logic [DW-1:0] ew, got;
      apply_reset();
      set_word(0, 12'h111);
      set_word(2, 12'h222);
      req = 4'b0101;
      for (int f = 0; f < 2; f++) begin
         e  = model_pick(req, model_ptr);
         ew = word(e);
         wait_ack(a, to);
         n_chk++;
         if (to || a !== onehot(e)) begin
            n_fail++;
            $display("FAIL simul_ack%0d: ack=%b timeout=%0d, required %b", f, a, to, onehot(e));
         end
         model_ptr = e;
         req[e] = 1'b0;
         @(negedge clk);
         n_chk++;
         if (ack !== '0) begin
            n_fail++;
            $display("FAIL simul_ack_width%0d: ack=%b one cycle later, required 0", f, ack);
         end
         got = (sent_q.size() > 0) ? sent_q.pop_front() : 'x;
         n_chk++;
         if (got !== ew) begin
            n_fail++;
            $display("FAIL simul_word%0d: slave got %h, required %h", f, got, ew);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [NR-1:0] a;
      bit to;
      int e;
      logic [DW-1:0] ew, got;
      apply_reset();
      for (int i = 0; i < NR; i++) set_word(i, DW'($urandom));
      req = '1;
      for (int f = 0; f < 6; f++) begin
         e  = model_pick(req, model_ptr);
         ew = word(e);
         wait_ack(a, to);
         n_chk++;
         if (to || a !== onehot(e)) begin
            n_fail++;
            $display("FAIL fair_frame%0d: ack=%b timeout=%0d, required %b", f, a, to, onehot(e));
         end
         model_ptr = e;
         req[e] = 1'b0;
         @(negedge clk);
         if (f == 5) req = '0;
         else begin
            set_word(e, DW'($urandom));
            req[e] = 1'b1;
         end
         got = (sent_q.size() > 0) ? sent_q.pop_front() : 'x;
         n_chk++;
         if (got !== ew) begin
            n_fail++;
            $display("FAIL fair_word%0d: slave got %h, required %h", f, got, ew);
         end
      end
   endtask

   task automatic test_drop_after_grant();
      logic [NR-1:0] a;
      bit to, regnt;
      logic [DW-1:0] w1, got;
      w1 = DW'($urandom);
      set_word(1, w1);
      req = 4'b0010;
      for (int i = 0; i < 200 && spi_cs; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      req = '0;
      set_word(1, ~w1);
      wait_ack(a, to);
      n_chk++;
      if (to || a !== 4'b0010) begin
         n_fail++;
         $display("FAIL drop_ack: ack=%b timeout=%0d, required 0010", a, to);
      end
      model_ptr = 1;
      regnt = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (gnt != '0) regnt = 1'b1;
      end
      n_chk++;
      if (regnt || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_no_regrant: regrant=%0d busy=%b, required 0 and 0", regnt, busy);
      end
      got = (sent_q.size() > 0) ? sent_q.pop_front() : 'x;
      n_chk++;
      if (got !== w1) begin
         n_fail++;
         $display("FAIL drop_word: slave got %h, required %h", got, w1);
      end
   endtask

   task automatic test_reset_mid();
      logic [NR-1:0] a;
      bit to;
      set_word(2, DW'($urandom));
      req = 4'b0100;
      for (int i = 0; i < 200 && spi_cs; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL mid_pre: busy=%b gnt=%b, required 1 and 0100", busy, gnt);
      end
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (gnt !== '0 || busy !== 1'b0 || ack !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: gnt=%b busy=%b ack=%b err=%b, required all 0", gnt, busy, ack, err);
      end
      rst = 1'b1;
      model_ptr = NR - 1;
      set_word(3, DW'($urandom));
      req = 4'b1000;
      for (int i = 0; i < 50 && gnt == '0; i++) @(negedge clk);
      n_chk++;
      if (gnt !== 4'b1000) begin
         n_fail++;
         $display("FAIL mid_regrant: gnt=%b, required 1000", gnt);
      end
      wait_ack(a, to);
      n_chk++;
      if (to || a !== 4'b1000) begin
         n_fail++;
         $display("FAIL mid_ack: ack=%b timeout=%0d, required 1000", a, to);
      end
      model_ptr = 3;
      req = '0;
      for (int i = 0; i < 200 && spi_cs !== 1'b1; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      sent_q.delete();
   endtask

   task automatic test_timeout();
      bit seen;
`ifdef SPI_ARB_TIMEOUT_EN
      int n;
      bit acked;
`else
      logic [NR-1:0] a;
      bit to;
      int errs;
`endif
      cs_tie = 1'b1;
      set_word(0, DW'($urandom));
      req = 4'b0001;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (spi_newd) begin seen = 1'b1; break; end
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL tmo_issue: newd never rose, required 1 within 50 cycles");
      end
`ifdef SPI_ARB_TIMEOUT_EN
      n = -1;
      acked = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (ack != '0) acked = 1'b1;
         if (err) begin n = i; break; end
         @(negedge clk);
      end
      req = '0;
      n_chk++;
      if (n != TMO || acked) begin
         n_fail++;
         $display("FAIL tmo_err: err after %0d cycles acked=%0d, required %0d and no ack", n, acked, TMO);
      end
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || err !== 1'b0 || ack !== '0) begin
         n_fail++;
         $display("FAIL tmo_after: busy=%b err=%b ack=%b, required all 0", busy, err, ack);
      end
      model_ptr = 0;
      cs_tie = 1'b0;
`else
      errs = 0;
      repeat (200) begin
         if (err) errs++;
         @(negedge clk);
      end
      n_chk++;
      if (errs != 0 || busy !== 1'b1 || spi_newd !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_disabled: err cycles=%0d busy=%b newd=%b, required 0, 1, 1", errs, busy, spi_newd);
      end
      cs_tie = 1'b0;
      wait_ack(a, to);
      n_chk++;
      if (to || a !== 4'b0001) begin
         n_fail++;
         $display("FAIL tmo_recover: ack=%b timeout=%0d, required 0001", a, to);
      end
      req = '0;
      model_ptr = 0;
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_back_to_back();
      test_drop_after_grant();
      test_reset_mid();
      test_timeout();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Round-robin controller that shares one SPI master between NUM_REQ requesters, each with a DATA_W-bit word to send. It picks a winner and presents the winner's word on spi_din. It holds spi_newd until the master asserts cs, waits for the frame to end (cs high again), then acks the requester. It sits between client logic and the spi_master/spi_top datapath, all on the system clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 12, SPI frame width; must match the master's din width
TIMEOUT_CYC, 1024, clk cycles allowed from ISSUE entry to frame end (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, the same clk that drives the SPI master
rst  in  1  synchronous, active-low reset (asserted when 0)
req  in  NUM_REQ  per-requester request level; held high until ack
req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  one-hot grant, high from ARB exit to ACK
ack  out  NUM_REQ  one-cycle completion pulse to the winner
err  out  1  one-cycle timeout pulse (tied 0 without the macro)
busy  out  1  high whenever state != IDLE
spi_newd  out  1  to master newd
spi_din  out  DATA_W  to master din, registered
spi_cs  in  1  master cs (active-low frame envelope)

Behaviour:
- Reset (rst==0 at posedge clk):
  - gnt=0, ack=0, err=0, busy=0, spi_newd=0, spi_din=0.
  - state=IDLE, rr pointer=NUM_REQ-1 (so requester 0 wins first), timeout counter=0, cs_q=1.
  - Reset applied mid-transfer aborts immediately: no ack, no err. The master's in-flight frame is not cancelled.
- cs_q is a registered copy of spi_cs; all cs decisions use cs_q.
- States: IDLE, ARB, ISSUE, BUSY, ACK.
- IDLE:
  - If |req, go to ARB; otherwise stay.
  - Minimum latency is 1 cycle from req to ARB.
- ARB (1 cycle):
  - Winner = first index with req set, searching upward from ptr+1 modulo NUM_REQ.
  - Register gnt[winner]=1 and spi_din=req_data[winner]; go to ISSUE.
  - If req has fallen to 0 in this cycle, return to IDLE with no grant.
- ISSUE:
  - spi_newd=1.
  - When cs_q==0, drop spi_newd and go to BUSY.
  - spi_newd must be held because the master samples newd only on sclk edges (up to 2*12 clk cycles).
- BUSY:
  - spi_newd=0; spi_din stays stable.
  - When cs_q==1, go to ACK.
- ACK (1 cycle):
  - ack[winner]=1, gnt=0, ptr=winner; go to IDLE.
  - The next arbitration is no earlier than 2 cycles after ack.
- req or req_data changing after ARB is ignored; the latched word is sent and ack still pulses.
- Requesters whose req is high but who are not granted wait indefinitely; there is no queue depth limit.
- Round-robin guarantee: with all req high, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- gnt is always one-hot or zero; ack is only ever asserted for an index whose gnt was high in the previous cycle.

Optional Feature:
SPI_ARB_TIMEOUT_EN:
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on ARB exit and increments each cycle in ISSUE or BUSY.
  - When it reaches TIMEOUT_CYC: err=1 for 1 cycle, spi_newd=0, gnt=0, no ack, ptr=winner, go to IDLE.
  - A frame end in the same cycle as the timeout takes priority, giving a normal ACK.
- Undefined: no counter; err is tied 0; ISSUE and BUSY wait indefinitely.

Decomposition:
- Package spi_arb_pkg holds:
  - the state enum arb_state_t {IDLE, ARB, ISSUE, BUSY, ACK};
  - the default constants SPI_DATA_W=12 and SPI_ARB_TIMEOUT_DEF=1024.
- One sub-module, rr_pick:
  - purely combinational;
  - inputs req and ptr; outputs a one-hot winner plus a valid flag;
  - also reusable by later shared-resource arbiters.

Test Plan:
- Single request: req=4'b0001, data0=12'hA5C, with spi_top attached -> spi_newd held until cs falls; ack[0] pulses once after cs rises; slave dout==12'hA5C; done seen.
- Simultaneous requests after reset: req=4'b0101, data0=12'h111, data2=12'h222 -> grants in order 0 then 2; slave dout 12'h111 then 12'h222; each ack 1 cycle wide.
- Fairness: all four req held high, each re-asserted after its ack -> grant order 0,1,2,3,0,1 over 6 frames; gnt never more than one-hot.
- Request dropped after grant: req[1] deasserted in BUSY -> frame completes, ack[1] still pulses, no new grant to 1.
- Reset mid-transfer: rst=0 for 1 cycle during BUSY -> next cycle gnt=0, busy=0, ack=0; after release with req=4'b1000, requester 3 is granted.
- Timeout (macro defined, TIMEOUT_CYC=64): spi_cs tied 1 -> err pulses exactly 64 cycles after ISSUE entry, no ack, busy low the next cycle. Macro undefined: err stays 0 and busy stays high.
